sort4_scheduler: RTL and testbench
==================================

Name: sort4_scheduler

Overview:
- Sorts a 4-lane vector of 8-bit unsigned values by time-sharing one `eight_bit_comparator` instance across a 5-step compare-swap network.
- Front end is a valid/ready load port, back end a valid/ready result port.
- Sits between a producer of byte quadruples and downstream min/max consumers.
- Trades area (one comparator instead of five) for 5 cycles of latency.

Parameters:
- None. Lane width is fixed at 8 bits by the comparator datapath; lane count is fixed at 4.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  producer has a vector on in_data/in_mode
- in_ready  out  1  block can accept a vector (high only in IDLE)
- in_data  in  32  lane k = in_data[8k+7:8k], k=0..3
- in_mode  in  1  0 = ascending (lane0 smallest), 1 = descending (lane0 largest)
- out_valid  out  1  sorted result available
- out_ready  in  1  consumer accepts result
- out_data  out  32  sorted vector, same lane mapping as in_data
- swap_count  out  3  number of swaps performed for this vector (0..5)
- busy  out  1  high in SORT state

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE, out_valid=0, out_data=0, swap_count=0, busy=0, step=0.
  - in_ready=1 from the cycle after reset.
  - rst overrides every other input on the same edge.
- States and transitions:
  - IDLE: in_ready=1. On an edge with in_valid=1, capture in_data into lane regs and in_mode into a mode reg, clear swap_count, set step=0, go to SORT.
  - SORT: busy=1, in_ready=0. Each cycle performs one compare-swap at step s:
    - pairs: s0=(0,1), s1=(2,3), s2=(0,2), s3=(1,3), s4=(1,2).
    - comparator inputs: a = lane i, b = lane j, with i < j.
    - swap condition: ascending, swap when g=1; descending, swap when l=1.
    - e=1 never swaps (stable for equal values).
    - on swap, exchange lanes i and j and increment swap_count.
    - after s4, go to DONE.
  - DONE: out_valid=1; out_data=lanes; swap_count holds its final value. On an edge with out_ready=1, go to IDLE.
- Timing:
  - Input accepted at edge T. Steps execute on edges T+1..T+5. out_valid=1 in the cycle following edge T+5.
  - Minimum accept-to-accept interval is 7 cycles.
  - No bypass: in_ready rises only in the cycle after the output handshake.
- Output stability:
  - While out_valid=1 and out_ready=0, out_data and swap_count stay constant for any number of cycles.
  - out_data and swap_count hold their last values in IDLE until the next accept clears swap_count.
- Input handling:
  - in_valid/in_data are ignored outside IDLE.
  - in_mode is sampled only at accept.
- Comparator use: exactly one `eight_bit_comparator` instance. Its operands are muxed by step; it is purely combinational with no extra register stage.
- Reset mid-SORT or mid-DONE aborts: the vector is discarded, no output handshake occurs, and in_ready=1 in the cycle after reset.
- Inputs contain no X/Z handling; the bench drives known values only.

Decomposition:
- Package sort4_pkg:
  - state encoding IDLE=2'd0, SORT=2'd1, DONE=2'd2.
  - constants NUM_STEPS=5 and LANE_W=8.
  - per-step pair index tables PAIR_I={0,2,0,1,1} and PAIR_J={1,3,2,3,2}.
- The only sub-module is the existing `eight_bit_comparator`, instantiated once. The operand mux, swap logic and FSM stay inline; no further sub-module is warranted.

Test Plan:
- Reverse ascending: in_data=32'h01020304, in_mode=0 -> out_data=32'h04030201, swap_count=4, out_valid in the cycle after edge T+5.
- Already sorted: in_data=32'h04030201, in_mode=0 -> out_data=32'h04030201, swap_count=0.
- Descending with ties: in_data=32'hAAAAAAAA, in_mode=1 -> out_data=32'hAAAAAAAA, swap_count=0. Then in_data=32'h04030201, in_mode=1 -> out_data=32'h01020304, swap_count=4.
- Backpressure: in_data=32'h10FF0080, mode 0, out_ready=0 for 3 cycles after out_valid -> out_data=32'hFF801000 stable for all 3 cycles; in_ready=0 throughout; in_ready=1 the cycle after the out_ready=1 edge.
- Reset mid-sort: accept 32'h01020304, assert rst for 1 cycle at step 2 -> next cycle out_valid=0, busy=0, swap_count=0, in_ready=1. A new vector then sorts correctly.
- Back-to-back: in_valid held high with two vectors and out_ready=1 constantly -> second accept occurs exactly 7 cycles after the first, and both results are correct.

Source files
------------

// File: rtl/sort4_pkg.sv
// Shared types and constants for the 4-lane byte sorter: FSM encoding and
// the compare-swap network pair tables.
package sort4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_STEPS = 5;
    localparam int LANE_W    = 8;

    // Packed tables, entry s at bits [2s+1:2s]: s0=(0,1) s1=(2,3) s2=(0,2) s3=(1,3) s4=(1,2)
    localparam logic [2*NUM_STEPS-1:0] PAIR_I = {2'd1, 2'd1, 2'd0, 2'd2, 2'd0};
    localparam logic [2*NUM_STEPS-1:0] PAIR_J = {2'd2, 2'd3, 2'd2, 2'd3, 2'd1};

    function automatic logic [1:0] pair_i(input logic [2:0] s);
        int unsigned idx;
        idx = 32'(s) * 2;
        if (32'(s) < NUM_STEPS) return PAIR_I[idx +: 2];
        return 2'd0;
    endfunction

    function automatic logic [1:0] pair_j(input logic [2:0] s);
        int unsigned idx;
        idx = 32'(s) * 2;
        if (32'(s) < NUM_STEPS) return PAIR_J[idx +: 2];
        return 2'd1;
    endfunction

endpackage

// File: rtl/eight_bit_comparator.sv
// Combinational unsigned 8-bit magnitude comparator: exactly one of g/e/l
// is high for any pair of operands.
module eight_bit_comparator (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       g,
    output logic       e,
    output logic       l
);

    assign g = (a > b);
    assign e = (a == b);
    assign l = (a < b);

endmodule

// File: rtl/sort4_scheduler.sv
// Sorts four unsigned bytes with a 5-step compare-swap network that reuses a
// single comparator, one step per clock.
module sort4_scheduler
    import sort4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  swap_count,
    output logic        busy
);

    state_e              state_q;
    logic [2:0]          step_q;
    logic                mode_q;
    logic [LANE_W-1:0]   lane_q [4];
    logic [LANE_W-1:0]   lane_d [4];
    logic [2:0]          swap_q;
    logic                out_valid_q;

    logic [1:0]          idx_i;
    logic [1:0]          idx_j;
    logic [LANE_W-1:0]   cmp_a;
    logic [LANE_W-1:0]   cmp_b;
    logic                cmp_g;
    logic                cmp_e;
    logic                cmp_l;
    logic                do_swap;

    assign idx_i = pair_i(step_q);
    assign idx_j = pair_j(step_q);
    assign cmp_a = lane_q[idx_i];
    assign cmp_b = lane_q[idx_j];

    eight_bit_comparator u_cmp (
        .a (cmp_a),
        .b (cmp_b),
        .g (cmp_g),
        .e (cmp_e),
        .l (cmp_l)
    );

    // Equal operands never swap, which keeps the network stable.
    assign do_swap = !cmp_e && (mode_q ? cmp_l : cmp_g);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_d[k] = lane_q[k];
            if (do_swap) begin
                if (2'(k) == idx_i)      lane_d[k] = cmp_b;
                else if (2'(k) == idx_j) lane_d[k] = cmp_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 3'd0;
            mode_q      <= 1'b0;
            swap_q      <= 3'd0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < 4; k++) lane_q[k] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 4; k++) lane_q[k] <= in_data[8*k +: 8];
                        mode_q  <= in_mode;
                        swap_q  <= 3'd0;
                        step_q  <= 3'd0;
                        state_q <= SORT;
                    end
                end
                SORT: begin
                    for (int k = 0; k < 4; k++) lane_q[k] <= lane_d[k];
                    if (do_swap) swap_q <= swap_q + 3'd1;
                    if (step_q == 3'(NUM_STEPS - 1)) begin
                        step_q      <= 3'd0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == SORT);
    assign out_valid  = out_valid_q;
    assign out_data   = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
    assign swap_count = swap_q;

endmodule

// File: tb/tb_sort4_scheduler.sv
// Directed and random checks of the time-shared 4-lane sorter, with a
// scoreboard of expected results built from an independent reference model.
module tb_sort4_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  swap_count;
    logic        busy;

    sort4_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .swap_count (swap_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  sw;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    // Sorted vector from a plain bubble sort; swap count from walking the pair network.
    function automatic exp_t model(input logic [31:0] d, input logic m);
        logic [7:0] s [4];
        logic [7:0] w [4];
        logic [7:0] t;
        int pi [5];
        int pj [5];
        exp_t r;
        pi[0] = 0; pi[1] = 2; pi[2] = 0; pi[3] = 1; pi[4] = 1;
        pj[0] = 1; pj[1] = 3; pj[2] = 2; pj[3] = 3; pj[4] = 2;
        for (int k = 0; k < 4; k++) begin
            s[k] = d[8*k +: 8];
            w[k] = d[8*k +: 8];
        end
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 3; k++)
                if ((!m && s[k] > s[k+1]) || (m && s[k] < s[k+1])) begin
                    t = s[k]; s[k] = s[k+1]; s[k+1] = t;
                end
        r.sw = 3'd0;
        for (int st = 0; st < 5; st++)
            if ((!m && w[pi[st]] > w[pj[st]]) || (m && w[pi[st]] < w[pj[st]])) begin
                t = w[pi[st]]; w[pi[st]] = w[pj[st]]; w[pj[st]] = t;
                r.sw = r.sw + 3'd1;
            end
        r.data = {s[3], s[2], s[1], s[0]};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, output exp_t e);
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            e = '0;
        end else begin
            e = sbq.pop_front();
            chk({tag, "_data"}, out_data, e.data);
            chk({tag, "_swaps"}, 32'(swap_count), 32'(e.sw));
        end
    endtask

    // Starts and ends on a falling edge; hold = cycles of out_ready low after out_valid.
    task automatic run_vec(input logic [31:0] d, input logic m, input int hold, input string tag);
        int   w;
        exp_t e;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        sbq.push_back(model(d, m));
        @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_in_ready_sort"}, 32'(in_ready), 32'd0);
        in_data = $urandom;
        in_mode = ~m;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_no_valid_early"}, 32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_no_valid_t4"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid_t5"}, 32'(out_valid), 32'd1);
        chk({tag, "_not_busy"}, 32'(busy), 32'd0);
        pop_check(tag, e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_data"}, out_data, e.data);
            chk({tag, "_hold_swaps"}, 32'(swap_count), 32'(e.sw));
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_data"}, out_data, e.data);
    endtask

    initial begin
        int   n_acc;
        int   n_out;
        int   acc_cyc [2];
        exp_t e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_swaps", 32'(swap_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        run_vec(32'h01020304, 1'b0, 0, "rev_asc");
        chk("rev_asc_const", sbq.size() == 0 ? model(32'h01020304, 1'b0) : 37'd0, {32'h04030201, 3'd4});
        run_vec(32'h04030201, 1'b0, 0, "sorted_asc");
        run_vec(32'hAAAAAAAA, 1'b1, 0, "ties_desc");
        run_vec(32'h04030201, 1'b1, 0, "rev_desc");
        run_vec(32'h10FF0080, 1'b0, 3, "backpressure");

        // Abort in the middle of sorting: step 2 is pending when rst is sampled.
        in_data  = 32'h01020304;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_swaps", 32'(swap_count), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        run_vec(32'h01020304, 1'b0, 0, "after_abort");

        for (int r = 0; r < 4; r++)
            run_vec($urandom, 1'($urandom_range(1)), r % 2, "random");

        // Back-to-back with in_valid held high and out_ready always high.
        n_acc     = 0;
        n_out     = 0;
        in_data   = 32'h01020304;
        in_mode   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && (n_acc < 2 || n_out < 2); k++) begin
            if (in_valid && in_ready) begin
                acc_cyc[n_acc] = cyc;
                sbq.push_back(model(in_data, in_mode));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                pop_check("b2b", e);
                n_out++;
            end
            @(negedge clk);
            if (n_acc == 1) in_data = 32'h10FF0080;
            if (n_acc == 2) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_accepts", 32'(n_acc), 32'd2);
        chk("b2b_outputs", 32'(n_out), 32'd2);
        if (n_acc == 2) chk("b2b_interval", 32'(acc_cyc[1] - acc_cyc[0]), 32'd7);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
